// File: rtl/i4002_ram_scanner.sv
// Read-only dump engine for one i4002: walks the read port of all four register
// arrays and streams every nibble on a valid/ready interface with reg/addr/last tags.
module i4002_ram_scanner #(
  parameter int unsigned NUM_CHARS  = 16,
  parameter int unsigned NUM_STATUS = 4,
  parameter bit          CONTINUOUS = 1'b0
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic [4:0] ram_addr2,
  input  logic [3:0] ram0_data2_in,
  input  logic [3:0] ram1_data2_in,
  input  logic [3:0] ram2_data2_in,
  input  logic [3:0] ram3_data2_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic [1:0] out_reg,
  output logic [4:0] out_addr,
  output logic       out_last
);

  localparam logic [4:0] LAST_MAIN = 5'(NUM_CHARS - 1);
  localparam logic [4:0] LAST_STAT = 5'(16 + NUM_STATUS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [4:0] addr_q, addr_d;
  logic [1:0] reg_q, reg_d;
  logic [3:0] data_q, data_d;
  logic [1:0] oreg_q, oreg_d;
  logic [4:0] oaddr_q, oaddr_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;

  logic [3:0] rd_nibble;
  logic [4:0] next_addr;
  logic [1:0] next_reg;
  logic       handshake;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      oreg_q  <= '0;
      oaddr_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      oreg_q  <= oreg_d;
      oaddr_q <= oaddr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign handshake = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_FETCH;
      S_FETCH:   state_d = S_PRESENT;
      S_PRESENT: if (handshake) state_d = last_q ? S_DONE : S_FETCH;
      S_DONE:    state_d = CONTINUOUS ? S_FETCH : S_IDLE;
    endcase
  end

  always_comb begin
    case (reg_q)
      2'd0:    rd_nibble = ram0_data2_in;
      2'd1:    rd_nibble = ram1_data2_in;
      2'd2:    rd_nibble = ram2_data2_in;
      default: rd_nibble = ram3_data2_in;
    endcase

    // Main range jumps straight to the status window; the final status slot wraps
    // to (reg+1, 0), which after reg 3 lands back on (0, 0) ready for a restart.
    next_reg = reg_q;
    if (addr_q == LAST_MAIN) begin
      next_addr = 5'b10000;
    end else if (addr_q == LAST_STAT) begin
      next_addr = '0;
      next_reg  = reg_q + 2'd1;
    end else begin
      next_addr = addr_q + 5'd1;
    end

    addr_d  = addr_q;
    reg_d   = reg_q;
    data_d  = data_q;
    oreg_d  = oreg_q;
    oaddr_d = oaddr_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = '0;
          reg_d  = '0;
        end
      end
      S_FETCH: begin
        data_d  = rd_nibble;
        oreg_d  = reg_q;
        oaddr_d = addr_q;
        valid_d = 1'b1;
        last_d  = (reg_q == 2'd3) && (addr_q == LAST_STAT);
      end
      S_PRESENT: begin
        if (handshake) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          addr_d  = next_addr;
          reg_d   = next_reg;
        end
      end
      S_DONE: ;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_FETCH) || (state_q == S_PRESENT);
    ram_addr2 = addr_q;
    out_valid = valid_q;
    out_data  = data_q;
    out_reg   = oreg_q;
    out_addr  = oaddr_q;
    out_last  = last_q;
  end

endmodule

// File: tb/tb_i4002_ram_scanner.sv
// Scoreboard bench for i4002_ram_scanner: a dump model fills expected-word queues,
// monitors pop and compare on every handshake and check held words under backpressure.
module tb_i4002_ram_scanner;

  logic       clk = 1'b0;
  logic       rst, start, ready;
  logic       busy, valid, last;
  logic [4:0] raddr, oaddr;
  logic [3:0] odata;
  logic [1:0] oreg;

  logic       rst_c, start_c;
  logic       c_busy, c_valid, c_last;
  logic [4:0] c_raddr, c_oaddr;
  logic [3:0] c_odata;
  logic [1:0] c_oreg;

  logic [3:0] mem [4][32];

  int n_checks = 0;
  int n_fail   = 0;
  int cnt      = 0;
  int ccnt     = 0;

  logic [11:0] q [$];
  logic [11:0] qc [$];

  always #5 clk = ~clk;

  i4002_ram_scanner #(.NUM_CHARS(16), .NUM_STATUS(4), .CONTINUOUS(1'b0)) dut (
    .sysclk(clk), .reset(rst), .start(start), .busy(busy), .ram_addr2(raddr),
    .ram0_data2_in(mem[0][raddr]), .ram1_data2_in(mem[1][raddr]),
    .ram2_data2_in(mem[2][raddr]), .ram3_data2_in(mem[3][raddr]),
    .out_valid(valid), .out_ready(ready), .out_data(odata), .out_reg(oreg),
    .out_addr(oaddr), .out_last(last)
  );

  i4002_ram_scanner #(.NUM_CHARS(16), .NUM_STATUS(4), .CONTINUOUS(1'b1)) dut_c (
    .sysclk(clk), .reset(rst_c), .start(start_c), .busy(c_busy), .ram_addr2(c_raddr),
    .ram0_data2_in(mem[0][c_raddr]), .ram1_data2_in(mem[1][c_raddr]),
    .ram2_data2_in(mem[2][c_raddr]), .ram3_data2_in(mem[3][c_raddr]),
    .out_valid(c_valid), .out_ready(1'b1), .out_data(c_odata), .out_reg(c_oreg),
    .out_addr(c_oaddr), .out_last(c_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected dump: every register, main characters then status characters.
  function automatic logic [11:0] word(input int r, input int a, input bit lst);
    logic [1:0] rr = 2'(r);
    logic [4:0] aa = 5'(a);
    return {rr, aa, mem[r][a], lst};
  endfunction

  task automatic push_dump(input bit to_c);
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 16; a++) begin
        if (to_c) qc.push_back(word(r, a, 1'b0)); else q.push_back(word(r, a, 1'b0));
      end
      for (int s = 0; s < 4; s++) begin
        if (to_c) qc.push_back(word(r, 16 + s, (r == 3) && (s == 3)));
        else      q.push_back(word(r, 16 + s, (r == 3) && (s == 3)));
      end
    end
  endtask

  // Monitor for the one-shot instance.
  logic        stall_v = 1'b0;
  logic [11:0] stall_w;
  always @(negedge clk) begin
    logic [11:0] cur, exp;
    cur = {oreg, oaddr, odata, last};
    if (rst) begin
      stall_v = 1'b0;
    end else if (valid) begin
      if (stall_v) check("held_word", 32'(cur), 32'(stall_w));
      if (ready) begin
        stall_v = 1'b0;
        if (q.size() == 0) begin
          check("unexpected_word", 32'(cur), 32'hFFFF);
        end else begin
          exp = q.pop_front();
          check($sformatf("word%0d {reg,addr,data,last}", cnt + 1), 32'(cur), 32'(exp));
        end
        cnt++;
      end else begin
        stall_v = 1'b1;
        stall_w = cur;
      end
    end
  end

  // Monitor for the continuous instance.
  always @(negedge clk) begin
    logic [11:0] cur, exp;
    cur = {c_oreg, c_oaddr, c_odata, c_last};
    if (!rst_c && c_valid) begin
      if (qc.size() == 0) begin
        check("cont_unexpected_word", 32'(cur), 32'hFFFF);
      end else begin
        exp = qc.pop_front();
        check($sformatf("cont_word%0d", ccnt + 1), 32'(cur), 32'(exp));
      end
      ccnt++;
    end
  end

  task automatic wait_cnt(input int target, input int budget, input string name);
    int b = budget;
    while (cnt < target && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (cnt < target) check({name, "_timeout"}, 32'(cnt), 32'(target));
  endtask

  task automatic finish_dump(input string name);
    wait_cnt(80, 600, name);
    repeat (4) @(negedge clk);
    check({name, "_count"}, 32'(cnt), 32'd80);
    check({name, "_queue_empty"}, 32'(q.size()), 32'd0);
    check({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic pulse_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  initial begin
    int b;
    for (int r = 0; r < 4; r++)
      for (int a = 0; a < 32; a++) mem[r][a] = 4'((r * 5 + a) & 4'hF);
    rst = 1'b1; rst_c = 1'b1; start = 1'b0; start_c = 1'b0; ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_last", 32'(last), 32'd0);
    check("rst_data", 32'(odata), 32'd0);
    check("rst_reg", 32'(oreg), 32'd0);
    check("rst_addr", 32'(oaddr), 32'd0);
    check("rst_ram_addr2", 32'(raddr), 32'd0);
    @(posedge clk); #1 rst = 1'b0; rst_c = 1'b0;

    // Full dump with latency check and an ignored start while busy.
    cnt = 0; push_dump(1'b0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("lat_valid_n1", 32'(valid), 32'd0);
    check("lat_busy_n1", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("lat_valid_n2", 32'(valid), 32'd1);
    repeat (5) @(posedge clk);
    pulse_start();
    finish_dump("dump1");

    // Backpressure: hold off word 10 for 7 cycles.
    cnt = 0; push_dump(1'b0);
    pulse_start();
    b = 200;
    do begin @(negedge clk); b--; end while (!(cnt == 9 && !valid) && b > 0);
    if (b == 0) check("bp_sync_timeout", 32'(cnt), 32'd9);
    ready = 1'b0;
    repeat (7) @(posedge clk);
    #1 ready = 1'b1;
    finish_dump("dump_bp");

    // Random RAM contents, random ready.
    for (int r = 0; r < 4; r++)
      for (int a = 0; a < 32; a++) mem[r][a] = 4'($urandom_range(0, 15));
    cnt = 0; push_dump(1'b0);
    pulse_start();
    b = 1000;
    while (cnt < 80 && b > 0) begin
      @(posedge clk); #1 ready = 1'($urandom_range(0, 1));
      b--;
    end
    @(posedge clk); #1 ready = 1'b1;
    finish_dump("dump_rand");

    // Reset while word 40 is presented, then a fresh dump.
    cnt = 0; push_dump(1'b0);
    pulse_start();
    b = 300;
    do begin @(negedge clk); b--; end while (!(cnt == 39 && !valid) && b > 0);
    if (b == 0) check("rst40_sync_timeout", 32'(cnt), 32'd39);
    ready = 1'b0;
    @(negedge clk);
    check("rst40_presented", 32'({valid, oaddr, oreg}), 32'({1'b1, 5'd19, 2'd1}));
    rst = 1'b1;
    @(negedge clk);
    check("rst40_busy", 32'(busy), 32'd0);
    check("rst40_valid", 32'(valid), 32'd0);
    check("rst40_ram_addr2", 32'(raddr), 32'd0);
    rst = 1'b0; ready = 1'b1;
    q.delete();
    cnt = 0; push_dump(1'b0);
    pulse_start();
    finish_dump("dump_after_rst");

    // Continuous instance: two back-to-back identical dumps from one start.
    ccnt = 0; push_dump(1'b1); push_dump(1'b1);
    @(posedge clk); #1 start_c = 1'b1;
    @(posedge clk); #1 start_c = 1'b0;
    b = 400;
    do begin @(negedge clk); b--; end while (!(c_valid && c_last) && b > 0);
    if (b == 0) check("cont_last1_timeout", 32'(ccnt), 32'd80);
    @(negedge clk);
    check("cont_done_busy", 32'(c_busy), 32'd0);
    check("cont_done_valid", 32'(c_valid), 32'd0);
    @(negedge clk);
    check("cont_restart_busy", 32'(c_busy), 32'd1);
    b = 400;
    do begin @(negedge clk); b--; end while (!(c_valid && c_last && ccnt >= 80) && b > 0);
    if (b == 0) check("cont_last2_timeout", 32'(ccnt), 32'd160);
    @(posedge clk); #1 rst_c = 1'b1;
    repeat (2) @(negedge clk);
    check("cont_count", 32'(ccnt), 32'd160);
    check("cont_queue_empty", 32'(qc.size()), 32'd0);
    rst_c = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
